alu_op_sequencer: RTL and testbench

//  Upstream feeder for the 4-bit combinational ALU. Accepts operand/opcode requests on a

---
 rtl/alu_op_sequencer_if.sv | 42 ++++
 rtl/alu_op_sequencer.sv | 200 ++++++++++++++++++++
 tb/tb_alu_op_sequencer.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_op_sequencer_if.sv
// Bundle of every handshake/bus signal around the ALU operation sequencer.
// Latency: none, wires only.
// Backpressure: carried by in_ready (request side) and res_ready (result side).
//
// Port summary (slave = sequencer side, master = environment side):
//   request : in_valid, in_ready, in_a, in_b, in_sel
//   ALU     : alu_a, alu_b, alu_sel (to ALU), alu_out (from ALU)
//   result  : res_valid, res_ready, res_data, res_sel
//   status  : op_count, busy
interface alu_op_sequencer_if #(
  parameter int WIDTH = 4,
  parameter int SEL_W = 2
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [SEL_W-1:0] in_sel;

  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [SEL_W-1:0] alu_sel;
  logic [WIDTH-1:0] alu_out;

  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_data;
  logic [SEL_W-1:0] res_sel;

  logic [7:0]       op_count;
  logic             busy;

  modport slave (
    input  in_valid, in_a, in_b, in_sel, alu_out, res_ready,
    output in_ready, alu_a, alu_b, alu_sel, res_valid, res_data, res_sel, op_count, busy
  );

  modport master (
    output in_valid, in_a, in_b, in_sel, alu_out, res_ready,
    input  in_ready, alu_a, alu_b, alu_sel, res_valid, res_data, res_sel, op_count, busy
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// Generic synchronous FIFO; power-of-2 depth, one extra pointer bit separates full from empty.
// Latency: a pushed entry is visible at pop_dat_o the cycle after the push edge.
// Backpressure: push ignored while full (no write-through), pop ignored while empty.
//
// Ports: clk, rst_n (async active-low), push_i/push_dat_i, pop_i/pop_dat_o, full_o, empty_o.
module fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic [W-1:0] push_dat_i,
  input  logic         pop_i,
  output logic [W-1:0] pop_dat_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_ptr_q;
  logic [AW:0]  rd_ptr_q;
  logic         do_push;
  logic         do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign pop_dat_o = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
    end
  end

  // Storage needs no reset: pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_dat_i;
  end
endmodule

// Feeds buffered operand/opcode requests to a combinational ALU and returns captured results.
// Latency: push edge E0 -> issue at E1 -> res_valid after E1+SETTLE; one result per SETTLE+1 cycles.
// Backpressure: in_ready = !fifo_full; result held stable until res_ready, FIFO refills meanwhile.
//
// Ports: clk, rst_n (async active-low), seq_if (slave modport of alu_op_sequencer_if):
//   request in_valid/in_ready/in_a/in_b/in_sel, ALU drive alu_a/alu_b/alu_sel with alu_out
//   return, result res_valid/res_ready/res_data/res_sel, status op_count/busy.
module alu_op_sequencer #(
  parameter int WIDTH      = 4,
  parameter int SEL_W      = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int SETTLE     = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  alu_op_sequencer_if.slave   seq_if
);
  typedef struct packed {
    logic [SEL_W-1:0] sel;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } req_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_OUT
  } state_t;

  localparam int             CW          = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0]  SETTLE_LAST = CW'(SETTLE - 1);
  localparam logic [CW-1:0]  CNT_ONE     = CW'(1);

  state_t           state_q;
  logic [CW-1:0]    settle_cnt_q;
  logic [WIDTH-1:0] alu_a_q;
  logic [WIDTH-1:0] alu_b_q;
  logic [SEL_W-1:0] alu_sel_q;
  logic             res_valid_q;
  logic [WIDTH-1:0] res_data_q;
  logic [SEL_W-1:0] res_sel_q;
  logic [7:0]       op_count_q;

  req_t push_req;
  req_t head_req;
  logic fifo_full;
  logic fifo_empty;
  logic pop;

  assign push_req.sel = seq_if.in_sel;
  assign push_req.a   = seq_if.in_a;
  assign push_req.b   = seq_if.in_b;

  // A new request is issued from IDLE, or from OUT in the same edge the result leaves,
  // which keeps back-to-back throughput at one result per SETTLE+1 cycles.
  assign pop = !fifo_empty &&
               ((state_q == ST_IDLE) || ((state_q == ST_OUT) && seq_if.res_ready));

  fifo #(
    .W     ($bits(req_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_req_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (seq_if.in_valid),
    .push_dat_i (push_req),
    .pop_i      (pop),
    .pop_dat_o  (head_req),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      settle_cnt_q <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_sel_q    <= '0;
      res_valid_q  <= 1'b0;
      res_data_q   <= '0;
      res_sel_q    <= '0;
      op_count_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pop) begin
            alu_a_q      <= head_req.a;
            alu_b_q      <= head_req.b;
            alu_sel_q    <= head_req.sel;
            settle_cnt_q <= '0;
            state_q      <= ST_SETTLE;
          end
        end

        ST_SETTLE: begin
          settle_cnt_q <= settle_cnt_q + CNT_ONE;
          // alu_out has had SETTLE full cycles since the drive registers changed.
          if (settle_cnt_q == SETTLE_LAST) begin
            res_data_q  <= seq_if.alu_out;
            res_sel_q   <= alu_sel_q;
            res_valid_q <= 1'b1;
            state_q     <= ST_OUT;
          end
        end

        ST_OUT: begin
          if (seq_if.res_ready) begin
            res_valid_q <= 1'b0;
            op_count_q  <= op_count_q + 8'd1;
            if (pop) begin
              alu_a_q      <= head_req.a;
              alu_b_q      <= head_req.b;
              alu_sel_q    <= head_req.sel;
              settle_cnt_q <= '0;
              state_q      <= ST_SETTLE;
            end else begin
              state_q <= ST_IDLE;
            end
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign seq_if.in_ready  = !fifo_full;
  assign seq_if.alu_a     = alu_a_q;
  assign seq_if.alu_b     = alu_b_q;
  assign seq_if.alu_sel   = alu_sel_q;
  assign seq_if.res_valid = res_valid_q;
  assign seq_if.res_data  = res_data_q;
  assign seq_if.res_sel   = res_sel_q;
  assign seq_if.op_count  = op_count_q;
  assign seq_if.busy      = (state_q != ST_IDLE) || !fifo_empty;

  // Held result must not change until it is taken.
  a_res_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (res_valid_q && !seq_if.res_ready) |=>
      (res_valid_q && $stable(res_data_q) && $stable(res_sel_q)));

  // ALU drives move only when a request is issued.
  a_alu_hold: assert property (@(posedge clk) disable iff (!rst_n)
    !pop |=> ($stable(alu_a_q) && $stable(alu_b_q) && $stable(alu_sel_q)));

  // res_valid is asserted exactly while waiting in OUT.
  a_valid_state: assert property (@(posedge clk) disable iff (!rst_n)
    res_valid_q == (state_q == ST_OUT));
endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer with an XOR stub ALU and a result scoreboard.
// Latency: checks issue/result timing against fixed cycle counts.
// Backpressure: drives res_ready low/high to exercise holding, FIFO fill and drain.
module tb_alu_op_sequencer;
  localparam int WIDTH      = 4;
  localparam int SEL_W      = 2;
  localparam int FIFO_DEPTH = 4;
  localparam int SETTLE     = 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_op_sequencer_if #(.WIDTH(WIDTH), .SEL_W(SEL_W)) bus ();

  alu_op_sequencer #(
    .WIDTH      (WIDTH),
    .SEL_W      (SEL_W),
    .FIFO_DEPTH (FIFO_DEPTH),
    .SETTLE     (SETTLE)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .seq_if (bus.slave)
  );

  // Stub ALU.
  assign bus.alu_out = bus.alu_a ^ bus.alu_b;

  typedef struct packed {
    logic [SEL_W-1:0] sel;
    logic [WIDTH-1:0] data;
  } exp_t;

  exp_t       sb_q[$];
  int         n_chk   = 0;
  int         n_fail  = 0;
  int         n_res   = 0;
  logic [7:0] exp_cnt = 8'd0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Mid-cycle monitor: a handshake seen here completes on the next rising edge.
  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst_n) begin
      sb_q.delete();
      exp_cnt = 8'd0;
    end else begin
      if (bus.in_valid && bus.in_ready) begin
        e.sel  = bus.in_sel;
        e.data = bus.in_a ^ bus.in_b;
        sb_q.push_back(e);
      end
      if (bus.res_valid && bus.res_ready) begin
        chk("sb_has_entry", 32'(sb_q.size() != 0), 1);
        if (sb_q.size() != 0) begin
          e = sb_q.pop_front();
          chk("sb_res_data", 32'(bus.res_data), 32'(e.data));
          chk("sb_res_sel", 32'(bus.res_sel), 32'(e.sel));
        end
        chk("sb_op_count", 32'(bus.op_count), 32'(exp_cnt));
        exp_cnt = exp_cnt + 8'd1;
        n_res++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                      input logic [SEL_W-1:0] sel);
    logic acc;
    int   n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_sel   = sel;
    do begin
      acc = bus.in_ready;
      tick();
      n++;
    end while (!acc && n < 200);
    if (!acc) chk("push_timeout", 0, 1);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_res(input int lim);
    int n;
    n = 0;
    while (!bus.res_valid && n < lim) begin
      tick();
      n++;
    end
    chk("wait_res_timeout", 32'(bus.res_valid), 1);
  endtask

  task automatic drain();
    int   n;
    logic done;
    n = 0;
    bus.res_ready = 1'b1;
    done = 1'b0;
    while (!done && n < 2000) begin
      tick();
      n++;
      done = (sb_q.size() == 0) && !bus.busy && !bus.res_valid;
    end
    chk("drain_timeout", 32'(done), 1);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : stim
    int base;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_sel    = '0;
    bus.res_ready = 1'b0;

    // Reset state.
    #12;
    chk("rst_res_valid", 32'(bus.res_valid), 0);
    chk("rst_outputs", 32'({bus.alu_a, bus.alu_b, bus.alu_sel, bus.res_data, bus.res_sel}), 0);
    chk("rst_op_count", 32'(bus.op_count), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    chk("rst_in_ready", 32'(bus.in_ready), 1);
    chk("rst_busy", 32'(bus.busy), 0);

    // 1: single op, latency and result.
    bus.res_ready = 1'b1;
    push(4'b0111, 4'b0001, 2'b00);
    chk("t1_valid_e0", 32'(bus.res_valid), 0);
    tick();
    chk("t1_valid_e1", 32'(bus.res_valid), 0);
    tick();
    chk("t1_valid_e2", 32'(bus.res_valid), 1);
    chk("t1_res_data", 32'(bus.res_data), 32'h6);
    chk("t1_res_sel", 32'(bus.res_sel), 0);
    tick();
    chk("t1_op_count", 32'(bus.op_count), 1);
    chk("t1_valid_done", 32'(bus.res_valid), 0);

    // 2: fill with result blocked: 1 in flight + 4 buffered.
    bus.res_ready = 1'b0;
    for (int i = 0; i < 5; i++) push(4'(i + 1), 4'(i * 9), 2'(i));
    chk("t2_full_in_ready", 32'(bus.in_ready), 0);
    bus.in_valid = 1'b1;
    bus.in_a     = 4'hF;
    bus.in_b     = 4'h0;
    bus.in_sel   = 2'd3;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t2_held_in_ready", 32'(bus.in_ready), 0);
    end
    bus.res_ready = 1'b1;
    push(4'hF, 4'h0, 2'd3);
    drain();
    chk("t2_op_count", 32'(bus.op_count), 7);

    // 3: backpressure hold for 10 cycles, then release.
    bus.res_ready = 1'b0;
    push(4'd3, 4'd9, 2'd2);
    push(4'd12, 4'd5, 2'd1);
    wait_res(20);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t3_hold",
          32'({bus.res_valid, bus.res_data, bus.res_sel, bus.alu_a, bus.alu_b, bus.alu_sel}),
          32'({1'b1, 4'hA, 2'd2, 4'd3, 4'd9, 2'd2}));
    end
    bus.res_ready = 1'b1;
    tick();
    chk("t3_release_gap", 32'(bus.res_valid), 0);
    tick();
    chk("t3_next_valid", 32'(bus.res_valid), 1);
    chk("t3_next_data", 32'({bus.res_data, bus.res_sel, bus.alu_a}), 32'({4'h9, 2'd1, 4'd12}));
    drain();

    // 4: 256 ops wrap op_count back to 0.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    chk("t4_count_start", 32'(bus.op_count), 0);
    base = n_res;
    bus.res_ready = 1'b1;
    for (int i = 0; i < 256; i++)
      push(4'($urandom_range(15)), 4'($urandom_range(15)), 2'($urandom_range(3)));
    drain();
    chk("t4_op_wrap", 32'(bus.op_count), 0);
    chk("t4_n_results", 32'(n_res - base), 256);

    // 5: reset while in SETTLE with 3 requests queued.
    bus.res_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(4'(i), 4'(15 - i), 2'(i));
    bus.res_ready = 1'b1;
    push(4'd7, 4'd7, 2'd3);
    chk("t5_pre_busy", 32'(bus.busy), 1);
    chk("t5_pre_settle", 32'(bus.res_valid), 0);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_res", 32'({bus.res_valid, bus.res_data, bus.res_sel}), 0);
    chk("t5_rst_alu", 32'({bus.alu_a, bus.alu_b, bus.alu_sel}), 0);
    chk("t5_rst_count", 32'(bus.op_count), 0);
    chk("t5_rst_busy", 32'(bus.busy), 0);
    tick();
    tick();
    rst_n = 1'b1;
    chk("t5_in_ready", 32'(bus.in_ready), 1);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("t5_no_pulse", 32'({bus.res_valid, bus.busy}), 0);
    end

    // 6: integration vector through the stub ALU.
    bus.res_ready = 1'b1;
    push(4'b0101, 4'b0011, 2'b01);
    wait_res(10);
    chk("t6_alu_data", 32'(bus.res_data), 32'h6);
    chk("t6_alu_sel", 32'(bus.res_sel), 1);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
